// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing, pixel coordinates and registered, blanked RGB output stage
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned PIX_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pix_en,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW = $clog2(PIX_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [7:0] r_q, g_q, b_q;
  logic h_last, v_last, visible, hs_d, vs_d;
  logic clk_q, frame_q, hs_q, vs_q, blank_n_q;
  assign pix_en = div_q == DW'(PIX_DIV - 1);
  always_comb begin
    div_d   = pix_en ? '0 : div_q + DW'(1);
    h_last  = hc_q == 10'(H_TOTAL - 1);
    v_last  = vc_q == 10'(V_TOTAL - 1);
    hc_d    = h_last ? '0 : hc_q + 10'd1;
    vc_d    = h_last ? (v_last ? '0 : vc_q + 10'd1) : vc_q;
    visible = hc_q < 10'(H_VISIBLE) && vc_q < 10'(V_VISIBLE);
    hs_d    = !(hc_q >= 10'(H_VISIBLE + H_FRONT) && hc_q < 10'(H_VISIBLE + H_FRONT + H_SYNC));
    vs_d    = !(vc_q >= 10'(V_VISIBLE + V_FRONT) && vc_q < 10'(V_VISIBLE + V_FRONT + V_SYNC));
  end
  // Output stage samples the pre-increment position, so it trails DrawX/DrawY by one pixel
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      clk_q     <= 1'b0;
      frame_q   <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      div_q   <= div_d;
      clk_q   <= div_d >= DW'(PIX_DIV / 2);
      frame_q <= pix_en && h_last && v_last;
      if (pix_en) begin
        hc_q      <= hc_d;
        vc_q      <= vc_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= visible;
        r_q       <= visible ? Red_in : '0;
        g_q       <= visible ? Green_in : '0;
        b_q       <= visible ? Blue_in : '0;
      end
    end
  end
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_start = frame_q;
  assign VGA_CLK     = clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random RGB against a position-arithmetic model, full-size and shrunken timings
module tb_vga_timing_gen;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [23:0] cur = '0;
  logic [23:0] last_a = '0, last_b = '0;
  int c = 0;
  int n_cmp = 0, n_bad = 0;
  logic [9:0] xa, ya, xb, yb;
  logic pea, fsa, cka, hsa, vsa, bna, sna, peb, fsb, ckb, hsb, vsb, bnb, snb;
  logic [7:0] ra, ga, ba, rb, gb, bb;
  always #5 Clk = ~Clk;
  vga_timing_gen u_a (
    .Clk(Clk), .Reset_n(Reset_n), .Red_in(cur[23:16]), .Green_in(cur[15:8]), .Blue_in(cur[7:0]),
    .DrawX(xa), .DrawY(ya), .pix_en(pea), .frame_start(fsa), .VGA_CLK(cka), .VGA_HS(hsa),
    .VGA_VS(vsa), .VGA_BLANK_N(bna), .VGA_SYNC_N(sna), .VGA_R(ra), .VGA_G(ga), .VGA_B(ba)
  );
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIX_DIV(4)
  ) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .Red_in(cur[23:16]), .Green_in(cur[15:8]), .Blue_in(cur[7:0]),
    .DrawX(xb), .DrawY(yb), .pix_en(peb), .frame_start(fsb), .VGA_CLK(ckb), .VGA_HS(hsb),
    .VGA_VS(vsb), .VGA_BLANK_N(bnb), .VGA_SYNC_N(snb), .VGA_R(rb), .VGA_G(gb), .VGA_B(bb)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask
  // Expected outputs follow from how many pixel periods have elapsed since reset release
  task automatic check_dut(input string t, input int pd, hv, hf, hw, hb, vv, vf, vw, vb,
                           input logic [23:0] lrgb, input logic [9:0] x, y,
                           input logic pe, fs, ck, hs, vs, bn, sn, input logic [23:0] rgb);
    int ht, vt, k, p, px, py;
    logic vis, ehs, evs;
    ht = hv + hf + hw + hb;
    vt = vv + vf + vw + vb;
    k = c / pd;
    ehs = 1'b1;
    evs = 1'b1;
    vis = 1'b0;
    if (k > 0) begin
      p = k - 1;
      px = p % ht;
      py = (p / ht) % vt;
      vis = px < hv && py < vv;
      ehs = !(px >= hv + hf && px < hv + hf + hw);
      evs = !(py >= vv + vf && py < vv + vf + vw);
    end
    chk({t, "_drawx"}, 32'(x), 32'(k % ht));
    chk({t, "_drawy"}, 32'(y), 32'((k / ht) % vt));
    chk({t, "_pix_en"}, 32'(pe), 32'((c % pd) == pd - 1));
    chk({t, "_vga_clk"}, 32'(ck), 32'((c % pd) >= pd / 2));
    chk({t, "_frame_start"}, 32'(fs), 32'(c > 0 && c % pd == 0 && k % (ht * vt) == 0));
    chk({t, "_hs"}, 32'(hs), 32'(ehs));
    chk({t, "_vs"}, 32'(vs), 32'(evs));
    chk({t, "_blank_n"}, 32'(bn), 32'(vis));
    chk({t, "_sync_n"}, 32'(sn), 32'd0);
    chk({t, "_rgb"}, 32'(rgb), 32'(vis ? lrgb : 24'h0));
  endtask
  task automatic check_all();
    check_dut("a", 2, 640, 16, 96, 48, 480, 10, 2, 33, last_a, xa, ya, pea, fsa, cka, hsa, vsa, bna, sna, {ra, ga, ba});
    check_dut("b", 4, 8, 2, 3, 2, 5, 1, 2, 1, last_b, xb, yb, peb, fsb, ckb, hsb, vsb, bnb, snb, {rb, gb, bb});
  endtask
  task automatic step();
    @(posedge Clk);
    if (c % 2 == 1) last_a = cur;
    if (c % 4 == 3) last_b = cur;
    c++;
    @(negedge Clk);
    check_all();
    cur = 24'($urandom);
  endtask
  task automatic pins();
    if (c == 1) chk("a_first_pix_en", 32'(pea), 32'd1);
    if (c == 2) chk("a_drawx_after_first", 32'(xa), 32'd1);
    if (c == 4) chk("a_drawx_two", 32'(xa), 32'd2);
    if (c == 1312) chk("a_hs_before_fall", 32'(hsa), 32'd1);
    if (c == 1314) chk("a_hs_fall_656", 32'(hsa), 32'd0);
    if (c == 1504) chk("a_hs_last_low", 32'(hsa), 32'd0);
    if (c == 1506) chk("a_hs_rise", 32'(hsa), 32'd1);
    if (c == 1600) chk("a_line_wrap", 32'({ya, xa}), 32'({10'd1, 10'd0}));
    if (c == 540) chk("b_frame_start", 32'({fsb, yb, xb}), 32'({1'b1, 10'd0, 10'd0}));
    if (c == 44) chk("b_hs_fall", 32'(hsb), 32'd0);
  endtask
  initial begin
    repeat (5) begin
      @(negedge Clk);
      check_all();
      chk("rst_outputs_a", 32'({hsa, vsa, bna, pea, ra}), 32'({1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
    end
    Reset_n = 1'b1;
    repeat (3400) begin
      step();
      pins();
    end
    #3 Reset_n = 1'b0;
    c = 0;
    #1 check_all();
    chk("mid_rst_async", 32'({xa, ya, hsa, bna, cka}), 32'({10'd0, 10'd0, 1'b1, 1'b0, 1'b0}));
    repeat (3) begin
      @(negedge Clk);
      check_all();
    end
    Reset_n = 1'b1;
    repeat (1700) begin
      step();
      pins();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Drives the DrawX/DrawY pixel coordinates consumed by the color mapper and the grid/block hit logic.
- Takes the mapper's combinational RGB back, then registers, blanks and aligns it with HS/VS for the board's video DAC.
- Also provides a per-frame tick for game logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_DIV, 2, Clk cycles per pixel; must be even and >= 2

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- Red_in  in  8  red from color mapper for current DrawX/DrawY
- Green_in  in  8  green from color mapper
- Blue_in  in  8  blue from color mapper
- DrawX  out  10  current horizontal pixel counter
- DrawY  out  10  current vertical line counter
- pix_en  out  1  one-Clk pulse per pixel period
- frame_start  out  1  one-Clk pulse at start of each frame
- VGA_CLK  out  1  pixel clock to DAC
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high in visible region
- VGA_SYNC_N  out  1  tied 0
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel color

Behaviour:
- Derived constants: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Reset (async, Reset_n=0), held immediately and for its duration, including mid-frame:
  - div_cnt=0, hc=0, vc=0, so DrawX=0, DrawY=0
  - pix_en=0, VGA_CLK=0, frame_start=0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0
- Divider:
  - div_cnt counts 0..PIX_DIV-1, wraps to 0.
  - pix_en = (div_cnt == PIX_DIV-1), combinational from the register.
  - VGA_CLK registered: 1 when next div_cnt >= PIX_DIV/2, else 0. With PIX_DIV=2 it is high exactly during pix_en cycles.
  - First pix_en occurs in Clk cycle PIX_DIV-1 after reset release.
- Counters advance only on Clk edges where pix_en=1:
  - hc increments, wraps H_TOTAL-1 -> 0.
  - vc increments only when hc wraps; vc wraps V_TOTAL-1 -> 0.
  - DrawX=hc, DrawY=vc (direct register outputs).
- Output stage: registered on the same pix_en edge from the pre-increment hc/vc and current *_in.
  - visible = hc < H_VISIBLE and vc < V_VISIBLE.
  - VGA_R/G/B = visible ? *_in : 0; VGA_BLANK_N = visible.
  - VGA_HS = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - Latency: outputs lag DrawX/DrawY by exactly one pixel period. All of sync, blank and RGB carry the same lag.
- Output stage holds between pix_en edges; no glitches on non-pix_en cycles.
- frame_start: registered. Set to 1 on the pix_en edge where hc=H_TOTAL-1 and vc=V_TOTAL-1, cleared next Clk. It is therefore high in the first Clk cycle with DrawX=0, DrawY=0 of a new frame. It does not fire on reset release.
- *_in is sampled only on pix_en edges. Mapper settling must complete within PIX_DIV-1 Clk cycles of a DrawX/DrawY change.
- Widths: hc/vc 10 bits. All comparisons are unsigned; no overflow, since totals are < 1024.

Test Plan:
- Reset:
  - Reset_n=0 for 5 Clk -> DrawX=DrawY=0, HS=VS=1, BLANK_N=0, RGB=0, pix_en=0.
  - Release -> pix_en first high in Clk cycle 1, DrawX=1 after cycle 1's edge, DrawX=2 after cycle 3's edge.
- Line timing:
  - 800 pix_en pulses between successive VGA_HS falling edges.
  - HS low for 96 pulses.
  - HS falls on the edge advancing DrawX 656->657.
  - DrawY increments when DrawX wraps 799->0.
- Frame timing:
  - VGA_VS low for 1600 pix_en pulses, falling on the edge where DrawY 490 begins registering.
  - frame_start period 420000 pix_en = 840000 Clk; each pulse coincides with DrawX=DrawY=0.
- Blanking: Red_in=Green_in=Blue_in=FF constant.
  - VGA_R=FF and BLANK_N=1 after edges registering hc 0..639, vc 0..479.
  - VGA_R=00 after the edge registering hc=640.
  - All 00 on lines 480..524.
- Alignment: Red_in driven as DrawX[7:0] -> VGA_R after successive edges on line 0 reads 00,01,02,...; reads 7F for hc=639, then 00.
- Mid-frame reset: assert Reset_n=0 at DrawX=300, DrawY=200 between Clk edges -> all outputs at reset values with no Clk edge; resumes cleanly from 0,0 after release.
